fpga_config_writer: RTL and testbench
=====================================

FPGA_CONFIG_WRITER -- requirements
Module: fpga_config_writer

Interface
REQ-001 SHALL have parameter MAX_CONNECTIONS, default 64, meaning record buffer depth.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning memory word width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning image start byte address.
REQ-005 SHALL have parameter MAGIC, default 32'h43464731, meaning header word 0.
REQ-006 SHALL have parameter VERSION, default 1, meaning header word 1.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-009 SHALL have port conn_write, input, 1, load strobe for one record.
REQ-010 SHALL have port conn_index, input, 6, target record slot.
REQ-011 SHALL have ports conn_switch_id/conn_my_ip/conn_peer_ip, input, 32 each, record fields.
REQ-012 SHALL have ports conn_my_port/conn_peer_port, input, 16 each, and conn_my_mac/conn_peer_mac, input, 48 each.
REQ-013 SHALL have port clear_records, input, 1, clears all slot-valid flags.
REQ-014 SHALL have ports start_write, input, 1; num_connections, input, 7; timestamp, input, 32.
REQ-015 SHALL have ports mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH; mem_we, output, 1; mem_ack, input, 1.
REQ-016 SHALL have ports busy, write_done, write_error, output, 1 each; words_written, output, 16.

Function
REQ-017 SHALL store a record and set its slot-valid flag on clk edge with conn_write=1 and busy=0; conn_write while busy SHALL be ignored.
REQ-018 SHALL clear all slot-valid flags on clear_records=1 when busy=0; clear_records beats conn_write in same cycle.
REQ-019 SHALL implement states IDLE, CHECK, HDR, CONN, DONE, ERR.
REQ-020 SHALL leave IDLE/DONE/ERR for CHECK on start_write=1, latching num_connections and timestamp, clearing write_done, write_error, words_written; start_write while busy ignored.
REQ-021 SHALL in CHECK (one cycle) go to ERR if num_connections > MAX_CONNECTIONS or any slot below num_connections lacks its valid flag, else to HDR.
REQ-022 SHALL in HDR emit words MAGIC, VERSION, zero-extended num_connections, timestamp.
REQ-023 SHALL in CONN emit 7 words per record k=0..N-1: switch_id, my_ip, peer_ip, {peer_port,my_port}, my_mac[31:0], {peer_mac[15:0],my_mac[47:32]}, peer_mac[47:16].
REQ-024 SHALL put word w at mem_addr = BASE_ADDR + 4*w, w counting from 0 at header word 0.
REQ-025 SHALL hold mem_we=1 with stable mem_addr/mem_wdata until a clk edge sees mem_ack=1, then advance one word next cycle (max one word per 2 cycles not required; back-to-back acks allowed, one word per cycle).
REQ-026 SHALL increment words_written once per acknowledged word; final value 4+7*N.
REQ-027 SHALL go from HDR to DONE directly when N=0 after word 3.
REQ-028 SHALL in DONE assert write_done=1 (level) until next start_write or reset.
REQ-029 SHALL in ERR assert write_error=1 (level), never assert mem_we, until next start_write or reset.
REQ-030 SHALL drive busy=1 exactly in CHECK, HDR, CONN.
REQ-031 SHALL ignore mem_ack when mem_we=0.

Reset
REQ-032 SHALL on rst=1 asynchronously enter IDLE, clear all slot-valid flags, drive mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, write_done=0, write_error=0, words_written=0.
REQ-033 SHALL abandon any in-progress image on rst mid-write with no further mem_we; record field contents need not reset.

Structure
REQ-034 SHALL place image layout constants (header word count 4, record word count 7, word offsets, state encoding) in shared package fpga_config_pkg, common with fpga_config_reader.
REQ-035 SHALL use one sub-module, fpga_config_record_mux, selecting record word by (slot, word offset) combinationally.

Verification
REQ-036 SHALL check: load 2 records, num_connections=2, mem_ack tied 1 -> 18 writes, addrs 0x00..0x44, word2=2, write_done=1, words_written=18.
REQ-037 SHALL check: record my_port=0x1234, peer_port=0x5678, my_mac=0x001122334455, peer_mac=0xAABBCCDDEEFF -> words 0x56781234, 0x22334455, 0xEEFF0011, 0xAABBCCDD.
REQ-038 SHALL check: num_connections=3 with slot 1 unloaded -> write_error=1, zero mem_we pulses.
REQ-039 SHALL check: num_connections=65 -> write_error=1; num_connections=0 -> exactly 4 header writes, then write_done.
REQ-040 SHALL check: mem_ack delayed 3 cycles per word -> addr/data stable while mem_we=1, same image as ack-tied case.
REQ-041 SHALL check: rst pulse after word 5 -> mem_we=0 immediately, all outputs at reset values, restart produces full image only after reloading records.

Source files
------------

// File: rtl/fpga_config_pkg.sv
// Layout of the configuration image shared by fpga_config_writer and fpga_config_reader:
// a 4-word header followed by 7 words per connection record.
package fpga_config_pkg;

    localparam int HDR_WORDS = 4;
    localparam int REC_WORDS = 7;
    localparam int SLOT_W    = 7;

    localparam logic [1:0] HDR_MAGIC   = 2'd0;
    localparam logic [1:0] HDR_VERSION = 2'd1;
    localparam logic [1:0] HDR_COUNT   = 2'd2;
    localparam logic [1:0] HDR_TSTAMP  = 2'd3;

    localparam logic [2:0] OFF_SWITCH_ID = 3'd0;
    localparam logic [2:0] OFF_MY_IP     = 3'd1;
    localparam logic [2:0] OFF_PEER_IP   = 3'd2;
    localparam logic [2:0] OFF_PORTS     = 3'd3;
    localparam logic [2:0] OFF_MAC_A     = 3'd4;
    localparam logic [2:0] OFF_MAC_B     = 3'd5;
    localparam logic [2:0] OFF_MAC_C     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HDR   = 3'd2,
        ST_CONN  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } cfg_state_t;

    typedef struct packed {
        logic [31:0] switch_id;
        logic [31:0] my_ip;
        logic [31:0] peer_ip;
        logic [15:0] my_port;
        logic [15:0] peer_port;
        logic [47:0] my_mac;
        logic [47:0] peer_mac;
    } conn_rec_t;

    // The two MACs are packed back to back across words 4..6 of a record.
    function automatic logic [31:0] rec_word(input conn_rec_t r, input logic [2:0] off);
        logic [31:0] w;
        case (off)
            OFF_SWITCH_ID: w = r.switch_id;
            OFF_MY_IP:     w = r.my_ip;
            OFF_PEER_IP:   w = r.peer_ip;
            OFF_PORTS:     w = {r.peer_port, r.my_port};
            OFF_MAC_A:     w = r.my_mac[31:0];
            OFF_MAC_B:     w = {r.peer_mac[15:0], r.my_mac[47:32]};
            OFF_MAC_C:     w = r.peer_mac[47:16];
            default:       w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fpga_config_record_mux.sv
// Combinational selection of one 32-bit image word from the record buffer by (slot, offset).
module fpga_config_record_mux
    import fpga_config_pkg::*;
#(
    parameter int MAX_CONNECTIONS = 64
) (
    input  conn_rec_t          recs_i [MAX_CONNECTIONS],
    input  logic [SLOT_W-1:0]  slot_i,
    input  logic [2:0]         off_i,
    output logic [31:0]        word_o
);

    localparam int IDX_W = (MAX_CONNECTIONS > 1) ? $clog2(MAX_CONNECTIONS) : 1;

    always_comb begin
        word_o = '0;
        if (int'(slot_i) < MAX_CONNECTIONS) begin
            word_o = rec_word(recs_i[IDX_W'(slot_i)], off_i);
        end
    end

endmodule

// File: rtl/fpga_config_writer.sv
// Streams a configuration image (header + connection records) to memory, one word per
// acknowledged write, after checking that every requested record slot has been loaded.
module fpga_config_writer
    import fpga_config_pkg::*;
#(
    parameter int                    MAX_CONNECTIONS = 64,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter logic [31:0]           MAGIC           = 32'h43464731,
    parameter logic [31:0]           VERSION         = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conn_write,
    input  logic [5:0]            conn_index,
    input  logic [31:0]           conn_switch_id,
    input  logic [31:0]           conn_my_ip,
    input  logic [31:0]           conn_peer_ip,
    input  logic [15:0]           conn_my_port,
    input  logic [15:0]           conn_peer_port,
    input  logic [47:0]           conn_my_mac,
    input  logic [47:0]           conn_peer_mac,
    input  logic                  clear_records,
    input  logic                  start_write,
    input  logic [6:0]            num_connections,
    input  logic [31:0]           timestamp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  write_done,
    output logic                  write_error,
    output logic [15:0]           words_written
);

    localparam int IDX_W = (MAX_CONNECTIONS > 1) ? $clog2(MAX_CONNECTIONS) : 1;

    cfg_state_t            state_q;
    logic [6:0]            num_q;
    logic [31:0]           ts_q;
    logic [1:0]            hdr_idx_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [2:0]            off_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [15:0]           words_q;

    conn_rec_t                  recs_q [MAX_CONNECTIONS];
    logic [MAX_CONNECTIONS-1:0] valid_q;
    logic [IDX_W-1:0]           wr_idx;
    logic                       wr_ok;
    logic                       chk_bad;
    logic                       ack_w;
    logic                       last_rec_word;
    logic [SLOT_W-1:0]          sel_slot_d;
    logic [2:0]                 sel_off_d;
    logic [31:0]                rec_word_w;

    function automatic logic [DATA_WIDTH-1:0] to_data(input logic [31:0] w);
        return DATA_WIDTH'(w);
    endfunction

    function automatic logic [31:0] hdr_word(input logic [1:0] idx, input logic [6:0] n,
                                             input logic [31:0] ts);
        logic [31:0] w;
        case (idx)
            HDR_MAGIC:   w = MAGIC;
            HDR_VERSION: w = VERSION;
            HDR_COUNT:   w = {25'd0, n};
            default:     w = ts;
        endcase
        return w;
    endfunction

    assign wr_idx = IDX_W'(conn_index);
    assign wr_ok  = int'(conn_index) < MAX_CONNECTIONS;
    assign ack_w  = mem_we_q && mem_ack;
    assign last_rec_word = (off_q == OFF_MAC_C) && ((slot_q + 7'd1) == num_q);

    // Record contents are plain data and are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (conn_write && !busy_q && !clear_records && wr_ok) begin
            recs_q[wr_idx] <= '{switch_id: conn_switch_id, my_ip: conn_my_ip,
                                peer_ip: conn_peer_ip, my_port: conn_my_port,
                                peer_port: conn_peer_port, my_mac: conn_my_mac,
                                peer_mac: conn_peer_mac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (!busy_q) begin
            if (clear_records) begin
                valid_q <= '0;
            end else if (conn_write && wr_ok) begin
                valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        chk_bad = int'(num_q) > MAX_CONNECTIONS;
        for (int i = 0; i < MAX_CONNECTIONS; i++) begin
            if (i < int'(num_q) && !valid_q[i]) chk_bad = 1'b1;
        end
    end

    // Look ahead to the word that follows the one currently on the bus.
    always_comb begin
        sel_slot_d = '0;
        sel_off_d  = '0;
        if (state_q == ST_CONN) begin
            if (off_q == OFF_MAC_C) begin
                sel_slot_d = slot_q + 7'd1;
            end else begin
                sel_slot_d = slot_q;
                sel_off_d  = off_q + 3'd1;
            end
        end
    end

    fpga_config_record_mux #(
        .MAX_CONNECTIONS(MAX_CONNECTIONS)
    ) u_record_mux (
        .recs_i (recs_q),
        .slot_i (sel_slot_d),
        .off_i  (sel_off_d),
        .word_o (rec_word_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            ts_q        <= '0;
            hdr_idx_q   <= '0;
            slot_q      <= '0;
            off_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_write) begin
                        state_q <= ST_CHECK;
                        num_q   <= num_connections;
                        ts_q    <= timestamp;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        words_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (chk_bad) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= ST_HDR;
                        hdr_idx_q   <= HDR_MAGIC;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR;
                        mem_wdata_q <= to_data(MAGIC);
                    end
                end
                ST_HDR: begin
                    if (ack_w) begin
                        words_q <= words_q + 16'd1;
                        if (hdr_idx_q != HDR_TSTAMP) begin
                            hdr_idx_q   <= hdr_idx_q + 2'd1;
                            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                            mem_wdata_q <= to_data(hdr_word(hdr_idx_q + 2'd1, num_q, ts_q));
                        end else if (num_q == '0) begin
                            state_q  <= ST_DONE;
                            mem_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            state_q     <= ST_CONN;
                            slot_q      <= '0;
                            off_q       <= '0;
                            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                            mem_wdata_q <= to_data(rec_word_w);
                        end
                    end
                end
                ST_CONN: begin
                    if (ack_w) begin
                        words_q <= words_q + 16'd1;
                        if (last_rec_word) begin
                            state_q  <= ST_DONE;
                            mem_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            slot_q      <= sel_slot_d;
                            off_q       <= sel_off_d;
                            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                            mem_wdata_q <= to_data(rec_word_w);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_we        = mem_we_q;
    assign busy          = busy_q;
    assign write_done    = done_q;
    assign write_error   = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_fpga_config_writer.sv
// Randomized bench for fpga_config_writer: a queue-based image model drives a per-cycle
// write monitor that also plays the memory, acknowledging with configurable latency.
module tb_fpga_config_writer;

    localparam int          MAXC      = 64;
    localparam logic [31:0] MAGIC_C   = 32'h43464731;
    localparam logic [31:0] VERSION_C = 32'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conn_write = 1'b0;
    logic [5:0]  conn_index = '0;
    logic [31:0] conn_switch_id = '0, conn_my_ip = '0, conn_peer_ip = '0;
    logic [15:0] conn_my_port = '0, conn_peer_port = '0;
    logic [47:0] conn_my_mac = '0, conn_peer_mac = '0;
    logic        clear_records = 1'b0;
    logic        start_write = 1'b0;
    logic [6:0]  num_connections = '0;
    logic [31:0] timestamp = '0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic        busy, write_done, write_error;
    logic [15:0] words_written;

    fpga_config_writer #(
        .MAX_CONNECTIONS(MAXC), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .BASE_ADDR(32'h0), .MAGIC(MAGIC_C), .VERSION(VERSION_C)
    ) dut (
        .clk(clk), .rst(rst),
        .conn_write(conn_write), .conn_index(conn_index),
        .conn_switch_id(conn_switch_id), .conn_my_ip(conn_my_ip), .conn_peer_ip(conn_peer_ip),
        .conn_my_port(conn_my_port), .conn_peer_port(conn_peer_port),
        .conn_my_mac(conn_my_mac), .conn_peer_mac(conn_peer_mac),
        .clear_records(clear_records), .start_write(start_write),
        .num_connections(num_connections), .timestamp(timestamp),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .write_done(write_done), .write_error(write_error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: what the software thinks is in each record slot.
    bit          m_valid   [MAXC];
    logic [31:0] m_sw      [MAXC];
    logic [31:0] m_myip    [MAXC];
    logic [31:0] m_peerip  [MAXC];
    logic [15:0] m_myp     [MAXC];
    logic [15:0] m_peerp   [MAXC];
    logic [47:0] m_mymac   [MAXC];
    logic [47:0] m_peermac [MAXC];

    logic [31:0] exp_q    [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] golden   [$];
    bit          exp_err;
    int          widx = 0;

    // 0: ack tied high, 1: ack after 3 waiting cycles, 2: random 0..3 cycles
    int          ack_mode = 0;
    int          cur_delay = 0;
    int          wait_cnt = 0;
    bit          prev_we = 1'b0;
    bit          prev_acked = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    function automatic int next_delay();
        if (ack_mode == 0) return 0;
        if (ack_mode == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (prev_we && !prev_acked) begin
                chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
                chk("data_stable", 64'(mem_wdata), 64'(prev_data));
            end
            if (widx < exp_q.size()) begin
                chk("mem_addr", 64'(mem_addr), 64'(32'(4 * widx)));
                chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[widx]));
            end else begin
                fail("unexpected_mem_we_word", 64'(widx), 64'(exp_q.size()));
            end
            if (wait_cnt >= cur_delay) begin
                mem_ack    = 1'b1;
                prev_acked = 1'b1;
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                widx++;
                wait_cnt  = 0;
                cur_delay = next_delay();
            end else begin
                mem_ack    = 1'b0;
                prev_acked = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack    = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            prev_acked = 1'b0;
            wait_cnt   = 0;
            cur_delay  = next_delay();
        end
        prev_we   = (mem_we === 1'b1);
        prev_addr = mem_addr;
        prev_data = mem_wdata;
    end

    task automatic load_rec(input int idx, input logic [31:0] sw, input logic [31:0] myip,
                            input logic [31:0] peerip, input logic [15:0] myp,
                            input logic [15:0] peerp, input logic [47:0] mymac,
                            input logic [47:0] peermac);
        conn_write = 1'b1;
        conn_index = 6'(idx);
        conn_switch_id = sw; conn_my_ip = myip; conn_peer_ip = peerip;
        conn_my_port = myp; conn_peer_port = peerp;
        conn_my_mac = mymac; conn_peer_mac = peermac;
        @(negedge clk);
        conn_write = 1'b0;
        m_valid[idx] = 1'b1;
        m_sw[idx] = sw; m_myip[idx] = myip; m_peerip[idx] = peerip;
        m_myp[idx] = myp; m_peerp[idx] = peerp;
        m_mymac[idx] = mymac; m_peermac[idx] = peermac;
    endtask

    task automatic load_random(input int idx);
        load_rec(idx, $urandom, $urandom, $urandom, 16'($urandom), 16'($urandom),
                 48'({$urandom, $urandom}), 48'({$urandom, $urandom}));
    endtask

    task automatic reload(input int idx);
        load_rec(idx, m_sw[idx], m_myip[idx], m_peerip[idx], m_myp[idx], m_peerp[idx],
                 m_mymac[idx], m_peermac[idx]);
    endtask

    task automatic clear_recs();
        clear_records = 1'b1;
        @(negedge clk);
        clear_records = 1'b0;
        for (int i = 0; i < MAXC; i++) m_valid[i] = 1'b0;
    endtask

    task automatic build_image(input int n, input logic [31:0] ts);
        exp_err = (n > MAXC);
        for (int i = 0; i < n && i < MAXC; i++) if (!m_valid[i]) exp_err = 1'b1;
        exp_q.delete();
        if (!exp_err) begin
            exp_q.push_back(MAGIC_C);
            exp_q.push_back(VERSION_C);
            exp_q.push_back(32'(n));
            exp_q.push_back(ts);
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(m_sw[k]);
                exp_q.push_back(m_myip[k]);
                exp_q.push_back(m_peerip[k]);
                exp_q.push_back({m_peerp[k], m_myp[k]});
                exp_q.push_back(m_mymac[k][31:0]);
                exp_q.push_back({m_peermac[k][15:0], m_mymac[k][47:32]});
                exp_q.push_back(m_peermac[k][47:16]);
            end
        end
    endtask

    task automatic begin_image(input int n, input logic [31:0] ts);
        build_image(n, ts);
        widx = 0;
        log_addr.delete();
        log_data.delete();
        start_write = 1'b1;
        num_connections = 7'(n);
        timestamp = ts;
        @(negedge clk);
        start_write = 1'b0;
        chk("busy_in_check", 64'(busy), 64'(1));
    endtask

    task automatic finish_image(input string tag);
        int cyc = 0;
        while (!(write_done === 1'b1 || write_error === 1'b1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) fail({tag, "_timeout"}, 64'(cyc), 64'(0));
        @(negedge clk);
        chk({tag, "_write_done"}, 64'(write_done), 64'(!exp_err));
        chk({tag, "_write_error"}, 64'(write_error), 64'(exp_err));
        chk({tag, "_words_written"}, 64'(words_written), 64'(exp_q.size()));
        chk({tag, "_writes_seen"}, 64'(widx), 64'(exp_q.size()));
        chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_write_done"}, 64'(write_done), 64'(0));
        chk({tag, "_write_error"}, 64'(write_error), 64'(0));
        chk({tag, "_words_written"}, 64'(words_written), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbad;
        int c;
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two records, ack tied high.
        ack_mode = 0;
        load_rec(0, 32'h0A0B0C0D, 32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678,
                 48'h001122334455, 48'hAABBCCDDEEFF);
        load_random(1);
        begin_image(2, 32'h5EED0001);
        finish_image("two_rec");
        chk("two_rec_count", 64'(log_data.size()), 64'(18));
        chk("two_rec_addr0", 64'(log_addr[0]), 64'h0);
        chk("two_rec_addr17", 64'(log_addr[17]), 64'h44);
        chk("two_rec_magic", 64'(log_data[0]), 64'h43464731);
        chk("two_rec_version", 64'(log_data[1]), 64'h1);
        chk("two_rec_word2", 64'(log_data[2]), 64'h2);
        chk("two_rec_tstamp", 64'(log_data[3]), 64'h5EED0001);
        chk("two_rec_switch", 64'(log_data[4]), 64'h0A0B0C0D);
        chk("two_rec_ports", 64'(log_data[7]), 64'h56781234);
        chk("two_rec_mac_a", 64'(log_data[8]), 64'h22334455);
        chk("two_rec_mac_b", 64'(log_data[9]), 64'hEEFF0011);
        chk("two_rec_mac_c", 64'(log_data[10]), 64'hAABBCCDD);
        golden = log_data;

        // Same image with a 3-cycle ack latency per word.
        ack_mode = 1;
        begin_image(2, 32'h5EED0001);
        finish_image("slow_ack");
        nbad = 0;
        for (int i = 0; i < 18; i++) if (log_data[i] !== golden[i]) nbad++;
        chk("slow_ack_same_image", 64'(nbad), 64'(0));

        // Missing slot 1 among three requested.
        clear_recs();
        load_random(0);
        load_random(2);
        ack_mode = 2;
        begin_image(3, $urandom);
        finish_image("missing_slot");

        // Too many connections, then an empty image.
        begin_image(65, $urandom);
        finish_image("too_many");
        ack_mode = 0;
        begin_image(0, 32'h00C0FFEE);
        finish_image("empty");
        chk("empty_count_word", 64'(log_data[2]), 64'h0);
        chk("empty_last_addr", 64'(log_addr[3]), 64'hC);

        // clear_records wins over a simultaneous conn_write.
        clear_records = 1'b1;
        conn_write = 1'b1;
        conn_index = 6'd0;
        @(negedge clk);
        clear_records = 1'b0;
        conn_write = 1'b0;
        for (int i = 0; i < MAXC; i++) m_valid[i] = 1'b0;
        begin_image(1, $urandom);
        finish_image("clear_beats_write");

        // Loads, clears and restarts while busy are ignored.
        for (int i = 0; i < 3; i++) load_random(i);
        ack_mode = 1;
        begin_image(3, 32'h0BADF00D);
        repeat (4) @(negedge clk);
        conn_write = 1'b1;
        conn_index = 6'd1;
        conn_switch_id = 32'hDEADBEEF;
        clear_records = 1'b1;
        start_write = 1'b1;
        num_connections = 7'd0;
        @(negedge clk);
        conn_write = 1'b0;
        clear_records = 1'b0;
        start_write = 1'b0;
        finish_image("busy_ignore");
        ack_mode = 0;
        begin_image(3, 32'h0BADF00D);
        finish_image("busy_ignore_rerun");

        // Randomized images.
        for (int it = 0; it < 8; it++) begin
            clear_recs();
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) load_random(i);
            if (n > 0 && $urandom_range(0, 2) == 0) begin
                clear_recs();
                for (int i = 0; i < n; i++) if (i != n / 2) load_random(i);
            end
            if ($urandom_range(0, 1) == 1) load_random(n + 3);
            ack_mode = 2;
            begin_image(n, $urandom);
            finish_image("random");
        end

        // Reset part-way through an image.
        clear_recs();
        load_random(0);
        load_random(1);
        ack_mode = 0;
        begin_image(2, 32'h12345678);
        c = 0;
        while (widx < 5 && c < 200) begin
            @(posedge clk);
            c++;
        end
        if (c >= 200) fail("midreset_wait", 64'(widx), 64'(5));
        exp_q.delete();
        #2 rst = 1'b1;
        for (int i = 0; i < MAXC; i++) m_valid[i] = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        chk("midreset_held_we", 64'(mem_we), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        begin_image(2, 32'h12345678);
        finish_image("after_reset_noreload");
        reload(0);
        reload(1);
        begin_image(2, 32'h12345678);
        finish_image("after_reset_reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
